// File: rtl/jk_seq_pkg.sv
// Shared types for the JK bank sequencer: command opcodes and controller states.
package jk_seq_pkg;

  typedef enum logic [1:0] {
    OP_HOLD   = 2'd0,
    OP_LOAD   = 2'd1,
    OP_TOGGLE = 2'd2,
    OP_COUNT  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRIVE  = 2'd1,
    S_CHECK  = 2'd2,
    S_FINISH = 2'd3
  } state_e;

  // Every op except LOAD builds on the shadow copy, so it needs one to exist.
  function automatic logic needs_history(input op_e op);
    return op != OP_LOAD;
  endfunction

endpackage

// File: rtl/jk_bank_sequencer_if.sv
// Command and status channel between a command source and the JK bank sequencer.
interface jk_bank_sequencer_if
  import jk_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LEN_W = 8
) ();

  logic             cmd_valid;
  logic             cmd_ready;
  op_e              cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [LEN_W-1:0] cmd_len;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_len,
    input  cmd_ready, busy, done, err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_len,
    output cmd_ready, busy, done, err
  );

endinterface

// File: rtl/jk_drive_calc.sv
// Combinational J/K mask generator; masks derive from the shadow value only, never from Q.
module jk_drive_calc
  import jk_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  op_e              op_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [WIDTH-1:0] exp_i,
  output logic [WIDTH-1:0] j_mask_o,
  output logic [WIDTH-1:0] k_mask_o,
  output logic [WIDTH-1:0] exp_next_o
);

  logic [WIDTH-1:0] inc_mask;

  // Bit i toggles on increment exactly when all lower bits are ones.
  always_comb begin
    logic carry;
    inc_mask = '0;
    carry    = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      inc_mask[i] = carry;
      carry       = carry & exp_i[i];
    end
  end

  // NOTE: every output gets a default before the case, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    j_mask_o   = '0;
    k_mask_o   = '0;
    exp_next_o = exp_i;
    case (op_i)
      OP_LOAD: begin
        j_mask_o   = data_i;
        k_mask_o   = ~data_i;
        exp_next_o = data_i;
      end
      OP_TOGGLE: begin
        j_mask_o   = data_i;
        k_mask_o   = data_i;
        exp_next_o = exp_i ^ data_i;
      end
      OP_COUNT: begin
        j_mask_o   = inc_mask;
        k_mask_o   = inc_mask;
        exp_next_o = exp_i + WIDTH'(1);
      end
      OP_HOLD: begin
        j_mask_o   = '0;
        k_mask_o   = '0;
        exp_next_o = exp_i;
      end
    endcase
  end

endmodule

// File: rtl/jk_bank_sequencer.sv
// Command-driven controller for a bank of JK flops: drives J/K per op, shadows the
// expected Q and checks the bank against it after every drive step.
module jk_bank_sequencer
  import jk_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LEN_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  jk_bank_sequencer_if.slave   ctl,
  output logic [WIDTH-1:0]     jk_j,
  output logic [WIDTH-1:0]     jk_k,
  input  logic [WIDTH-1:0]     jk_q
);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic             exp_valid_q, exp_valid_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] jk_j_q, jk_j_d;
  logic [WIDTH-1:0] jk_k_q, jk_k_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             accept;
  op_e              calc_op;
  logic [WIDTH-1:0] calc_data;
  logic [WIDTH-1:0] j_mask, k_mask, exp_next;
  logic [LEN_W-1:0] eff_len;

  assign accept = ctl.cmd_valid && (state_q == S_IDLE);

  // The first drive step uses the incoming command; repeats use the captured one.
  assign calc_op   = (state_q == S_IDLE) ? ctl.cmd_op   : op_q;
  assign calc_data = (state_q == S_IDLE) ? ctl.cmd_data : data_q;

  assign eff_len = (ctl.cmd_op == OP_LOAD || ctl.cmd_len == '0)
                   ? LEN_W'(1) : ctl.cmd_len;

  jk_drive_calc #(.WIDTH(WIDTH)) u_calc (
    .op_i       (calc_op),
    .data_i     (calc_data),
    .exp_i      (exp_q),
    .j_mask_o   (j_mask),
    .k_mask_o   (k_mask),
    .exp_next_o (exp_next)
  );

  // The shadow value advances on the edge that enters DRIVE, so during CHECK
  // it already holds what the bank should show after that drive.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    data_d      = data_q;
    exp_d       = exp_q;
    exp_valid_d = exp_valid_q;
    rem_d       = rem_q;
    jk_j_d      = '0;
    jk_k_d      = '0;
    done_d      = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d   = ctl.cmd_op;
          data_d = ctl.cmd_data;
          if (needs_history(ctl.cmd_op) && !exp_valid_q) begin
            err_d = 1'b1;
          end else begin
            state_d = S_DRIVE;
            rem_d   = eff_len;
            jk_j_d  = j_mask;
            jk_k_d  = k_mask;
            exp_d   = exp_next;
            if (ctl.cmd_op == OP_LOAD) exp_valid_d = 1'b1;
          end
        end
      end

      S_DRIVE: begin
        rem_d   = rem_q - LEN_W'(1);
        state_d = S_CHECK;
      end

      S_CHECK: begin
        if (jk_q != exp_q) begin
          err_d       = 1'b1;
          exp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end else if (rem_q != '0) begin
          state_d = S_DRIVE;
          jk_j_d  = j_mask;
          jk_k_d  = k_mask;
          exp_d   = exp_next;
        end else begin
          state_d = S_FINISH;
          done_d  = 1'b1;
        end
      end

      S_FINISH: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= OP_HOLD;
      data_q      <= '0;
      exp_q       <= '0;
      exp_valid_q <= 1'b0;
      rem_q       <= '0;
      jk_j_q      <= '0;
      jk_k_q      <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      data_q      <= data_d;
      exp_q       <= exp_d;
      exp_valid_q <= exp_valid_d;
      rem_q       <= rem_d;
      jk_j_q      <= jk_j_d;
      jk_k_q      <= jk_k_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign jk_j          = jk_j_q;
  assign jk_k          = jk_k_q;
  assign ctl.busy      = (state_q != S_IDLE);
  assign ctl.cmd_ready = (state_q == S_IDLE);
  assign ctl.done      = done_q;
  assign ctl.err       = err_q;

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Directed bench for jk_bank_sequencer driving a behavioural 8-bit JK bank, with a
// response scoreboard for done/err pulses.
module tb_jk_bank_sequencer;
  import jk_seq_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [7:0] jk_j, jk_k, jk_q;
  logic [7:0] bank_q;
  logic [7:0] flip_mask;

  jk_bank_sequencer_if #(.WIDTH(8), .LEN_W(8)) bus ();

  jk_bank_sequencer #(.WIDTH(8), .LEN_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ctl   (bus),
    .jk_j  (jk_j),
    .jk_k  (jk_k),
    .jk_q  (jk_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bank of eight JK flops: Q+ = J&~Q | ~K&Q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bank_q <= 8'h00;
    else        bank_q <= (jk_j & ~bank_q) | (~jk_k & bank_q);
  end

  assign jk_q = bank_q ^ flip_mask;

  typedef struct {
    bit         is_err;
    logic [7:0] q;
    string      tag;
  } resp_t;

  resp_t sb[$];
  resp_t mon_r;

  int errors   = 0;
  int checks   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;

  logic [7:0] first_j, first_k;
  logic       first_busy;
  logic [7:0] qtrace [0:40];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Response monitor: every done/err pulse is matched against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && (bus.done || bus.err)) begin
      if (bus.done) done_cnt++;
      if (bus.err)  err_cnt++;
      check("done_err_exclusive", {31'd0, bus.done && bus.err}, 32'd0);
      check("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        mon_r = sb.pop_front();
        check({mon_r.tag, "_kind_err"}, {31'd0, bus.err}, {31'd0, mon_r.is_err});
        check({mon_r.tag, "_q"}, {24'd0, bank_q}, {24'd0, mon_r.q});
      end
    end
  end

  // Issue one command, queue its expected response and measure response latency
  // in cycles after the accepting edge (bounded wait).
  task automatic do_cmd(input op_e op, input logic [7:0] data, input logic [7:0] len,
                        input string tag, input bit exp_err, input logic [7:0] exp_q,
                        input int exp_lat);
    resp_t r;
    int    c;
    @(negedge clk);
    check({tag, "_ready"}, {31'd0, bus.cmd_ready}, 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = data;
    bus.cmd_len   = len;
    r.is_err = exp_err;
    r.q      = exp_q;
    r.tag    = tag;
    sb.push_back(r);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    c          = 0;
    first_j    = jk_j;
    first_k    = jk_k;
    first_busy = bus.busy;
    qtrace[0]  = bank_q;
    while (!(bus.done || bus.err) && c < 40) begin
      @(negedge clk);
      c++;
      qtrace[c] = bank_q;
    end
    check({tag, "_latency"}, c, exp_lat);
  endtask

  initial begin
    rst_n         = 1'b0;
    flip_mask     = 8'h00;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_HOLD;
    bus.cmd_data  = 8'h00;
    bus.cmd_len   = 8'h00;

    repeat (3) @(negedge clk);
    check("rst_jk_j", {24'd0, jk_j}, 32'h0);
    check("rst_jk_k", {24'd0, jk_k}, 32'h0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_err",  {31'd0, bus.err},  32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", {31'd0, bus.cmd_ready}, 32'd1);

    // Non-LOAD with no shadow copy is rejected without driving the bank.
    do_cmd(OP_COUNT, 8'h00, 8'd3, "count_rejected", 1'b1, 8'h00, 0);
    check("rej_no_drive_j", {24'd0, first_j}, 32'h0);
    check("rej_no_drive_k", {24'd0, first_k}, 32'h0);
    check("rej_no_done", done_cnt, 0);

    do_cmd(OP_LOAD, 8'hA5, 8'd0, "load_a5", 1'b0, 8'hA5, 2);
    check("load_a5_j", {24'd0, first_j}, 32'hA5);
    check("load_a5_k", {24'd0, first_k}, 32'h5A);
    check("load_a5_busy", {31'd0, first_busy}, 32'd1);

    // COUNT across the wrap point.
    do_cmd(OP_LOAD, 8'hFE, 8'd0, "load_fe", 1'b0, 8'hFE, 2);
    do_cmd(OP_COUNT, 8'h00, 8'd3, "count3", 1'b0, 8'h01, 6);
    check("count3_step1", {24'd0, qtrace[1]}, 32'hFF);
    check("count3_step2", {24'd0, qtrace[3]}, 32'h00);
    check("count3_step3", {24'd0, qtrace[5]}, 32'h01);

    do_cmd(OP_LOAD, 8'h0F, 8'd0, "load_0f", 1'b0, 8'h0F, 2);
    do_cmd(OP_TOGGLE, 8'h3C, 8'd2, "toggle2", 1'b0, 8'h0F, 4);
    check("toggle2_step1", {24'd0, qtrace[1]}, 32'h33);
    check("toggle2_step2", {24'd0, qtrace[3]}, 32'h0F);
    do_cmd(OP_HOLD, 8'h00, 8'd0, "hold_len0", 1'b0, 8'h0F, 2);

    // Corrupted Q during CHECK aborts with one err pulse and drops the shadow copy.
    flip_mask = 8'h01;
    do_cmd(OP_HOLD, 8'h00, 8'd4, "mismatch", 1'b1, 8'h0F, 2);
    flip_mask = 8'h00;
    do_cmd(OP_COUNT, 8'h00, 8'd1, "count_after_abort", 1'b1, 8'h0F, 0);

    // Reset in the middle of a COUNT drive step.
    do_cmd(OP_LOAD, 8'h10, 8'd0, "load_10", 1'b0, 8'h10, 2);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_COUNT;
    bus.cmd_data  = 8'h00;
    bus.cmd_len   = 8'd5;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    check("midcount_j", {24'd0, jk_j}, 32'h01);
    check("midcount_busy", {31'd0, bus.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_j", {24'd0, jk_j}, 32'h0);
    check("async_rst_k", {24'd0, jk_k}, 32'h0);
    check("async_rst_busy", {31'd0, bus.busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", {31'd0, bus.cmd_ready}, 32'd1);
    do_cmd(OP_COUNT, 8'h00, 8'd2, "count_after_reset", 1'b1, 8'h00, 0);
    do_cmd(OP_LOAD, 8'h3C, 8'd7, "load_3c", 1'b0, 8'h3C, 2);

    repeat (3) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    check("done_pulses", done_cnt, 8);
    check("err_pulses", err_cnt, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
